imem_resp: RTL and testbench



---
 rtl/imem_resp.sv | 122 ++++++++++++
 tb/tb_imem_resp.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_resp.sv
// Instruction-memory responder: one outstanding fetch, programmable latency,
// valid/ready response channel, and an independent preload write port.
module imem_resp #(
    parameter logic [31:0] ADDR_BASE   = 32'h80000000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [31:0]                    req_addr_i,
    output logic                           resp_valid_o,
    input  logic                           resp_ready_i,
    output logic [31:0]                    resp_instr_o,
    output logic                           resp_err_o,
    input  logic                           load_en_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_i,
    input  logic [31:0]                    load_data_i
);

    localparam int unsigned AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0] rd_addr;
    logic [31:0] rd_off;
    logic [AW-1:0] rd_idx;
    logic        rd_err;
    logic        fetch;

    // With LATENCY==1 the read happens on the accept edge, so decode the live address there.
    always_comb begin
        rd_addr = (state_q == S_IDLE) ? req_addr_i : addr_q;
        rd_off  = rd_addr - ADDR_BASE;
        rd_idx  = rd_off[AW+1:2];
        rd_err  = (rd_addr[1:0] != 2'b00) || (rd_addr < ADDR_BASE) ||
                  ((rd_off >> 2) >= 32'(DEPTH_WORDS));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        err_d   = err_q;
        fetch   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d = req_addr_i;
                    cnt_d  = LAT_M1;
                    if (LATENCY > 1) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_RESP;
                        fetch   = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    fetch   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (fetch) begin
            err_d   = rd_err;
            instr_d = rd_err ? '0 : mem_q[rd_idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately not reset; a same-edge write is not seen by the fetch read.
    always_ff @(posedge clk_i) begin
        if (load_en_i) begin
            mem_q[load_addr_i] <= load_data_i;
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_instr_o = instr_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_imem_resp.sv
// Scoreboard bench for imem_resp: three instances (LATENCY 2, 1, 15) share
// address/load inputs, each with its own handshake signals.
module tb_imem_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid, resp_ready, req_ready, resp_valid, resp_err;
    logic [31:0] req_addr;
    logic [31:0] instr [3];
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [32:0] sb_q [$];

    always #5 clk = ~clk;

    imem_resp #(.ADDR_BASE(32'h80000000), .DEPTH_WORDS(1024), .LATENCY(2)) u_lat2 (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_addr_i(req_addr),
        .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
        .resp_instr_o(instr[0]), .resp_err_o(resp_err[0]),
        .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
    );

    imem_resp #(.ADDR_BASE(32'h80000000), .DEPTH_WORDS(1024), .LATENCY(1)) u_lat1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_addr_i(req_addr),
        .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
        .resp_instr_o(instr[1]), .resp_err_o(resp_err[1]),
        .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
    );

    imem_resp #(.ADDR_BASE(32'h80000000), .DEPTH_WORDS(1024), .LATENCY(15)) u_lat15 (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]), .req_addr_i(req_addr),
        .resp_valid_o(resp_valid[2]), .resp_ready_i(resp_ready[2]),
        .resp_instr_o(instr[2]), .resp_err_o(resp_err[2]),
        .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input int unsigned a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = 10'(a);
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // Entered and left just after a negedge. Latency = cycles from the accept cycle to resp_valid.
    task automatic fetch(input int d, input logic [31:0] addr, input logic [31:0] exp_i,
                         input logic exp_e, input int exp_lat, input int hold,
                         input bit collide, input logic [31:0] col_data);
        int          lat = 0;
        bit          rdy_bad = 1'b0;
        bit          stable = 1'b1;
        logic [32:0] e;
        logic [31:0] held;
        sb_q.push_back({exp_e, exp_i});
        check("req_ready_idle", 32'(req_ready[d]), 32'd1);
        req_addr      = addr;
        req_valid[d]  = 1'b1;
        resp_ready[d] = (hold == 0);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid[d] = 1'b0;
                req_addr     = 32'hDEADBEEF;
            end
            if (collide && c == exp_lat - 1) begin
                load_en   = 1'b1;
                load_addr = 10'((addr - 32'h80000000) >> 2);
                load_data = col_data;
            end
            if (c == exp_lat) load_en = 1'b0;
            if (resp_valid[d]) begin
                lat = c;
                break;
            end
            if (req_ready[d]) rdy_bad = 1'b1;
        end
        load_en = 1'b0;
        check("latency", 32'(lat), 32'(exp_lat));
        check("req_ready_low_wait", 32'(rdy_bad), 32'd0);
        e = sb_q.pop_front();
        if (lat != 0) begin
            check("instr", instr[d], e[31:0]);
            check("err", 32'(resp_err[d]), 32'(e[32]));
            check("req_ready_resp", 32'(req_ready[d]), 32'd0);
            if (hold > 0) begin
                held = instr[d];
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    if (!resp_valid[d] || instr[d] !== held || req_ready[d]) stable = 1'b0;
                end
                check("backpressure_hold", 32'(stable), 32'd1);
                resp_ready[d] = 1'b1;
            end
            @(negedge clk);
            check("valid_drop", 32'(resp_valid[d]), 32'd0);
            check("ready_back", 32'(req_ready[d]), 32'd1);
        end
        resp_ready[d] = 1'b0;
    endtask

    task automatic b2b(input int d, input int period);
        int acc [$];
        int cyc = 0;
        req_addr      = 32'h80000000;
        req_valid[d]  = 1'b1;
        resp_ready[d] = 1'b1;
        while (acc.size() < 3 && cyc < 100) begin
            if (req_ready[d]) acc.push_back(cyc);
            @(negedge clk);
            cyc++;
        end
        req_valid[d] = 1'b0;
        check("b2b_count", 32'(acc.size()), 32'd3);
        if (acc.size() == 3) begin
            check("b2b_period1", 32'(acc[1] - acc[0]), 32'(period));
            check("b2b_period2", 32'(acc[2] - acc[1]), 32'(period));
        end
        for (int c = 0; c < 40 && !req_ready[d]; c++) @(negedge clk);
        check("b2b_drain", 32'(req_ready[d]), 32'd1);
        resp_ready[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = 1'b0; req_valid = '0; resp_ready = '0; req_addr = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(resp_valid[0]), 32'd0);
        check("rst_instr", instr[0], 32'd0);
        check("rst_err", 32'(resp_err[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(req_ready[0]), 32'd1);

        load(0, 32'h00100093);
        load(1, 32'h00100073);
        load(3, 32'hAAAA0000);
        load(5, 32'hCAFEF00D);
        load(1023, 32'h1234ABCD);

        fetch(0, 32'h80000000, 32'h00100093, 1'b0, 2, 0, 1'b0, 32'h0);
        fetch(0, 32'h80000004, 32'h00100073, 1'b0, 2, 0, 1'b0, 32'h0);
        fetch(0, 32'h80000014, 32'hCAFEF00D, 1'b0, 2, 5, 1'b0, 32'h0);
        fetch(0, 32'h80000FFC, 32'h1234ABCD, 1'b0, 2, 0, 1'b0, 32'h0);
        fetch(0, 32'h80000002, 32'h00000000, 1'b1, 2, 0, 1'b0, 32'h0);
        fetch(0, 32'h7FFFFFFC, 32'h00000000, 1'b1, 2, 0, 1'b0, 32'h0);
        fetch(0, 32'h80001000, 32'h00000000, 1'b1, 2, 0, 1'b0, 32'h0);
        fetch(0, 32'h8000000C, 32'hAAAA0000, 1'b0, 2, 0, 1'b1, 32'h12345678);
        fetch(0, 32'h8000000C, 32'h12345678, 1'b0, 2, 0, 1'b0, 32'h0);

        fetch(1, 32'h80000000, 32'h00100093, 1'b0, 1, 0, 1'b0, 32'h0);
        fetch(1, 32'h80000002, 32'h00000000, 1'b1, 1, 0, 1'b0, 32'h0);
        fetch(2, 32'h80000004, 32'h00100073, 1'b0, 15, 0, 1'b0, 32'h0);

        b2b(0, 3);
        b2b(1, 2);
        b2b(2, 16);

        // Reset while the LATENCY=15 instance is in WAIT; it holds a nonzero word beforehand.
        req_addr     = 32'h80000014;
        req_valid[2] = 1'b1;
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(resp_valid[2]), 32'd0);
        check("midrst_instr", instr[2], 32'd0);
        check("midrst_err", 32'(resp_err[2]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (resp_valid[2]) seen = 1'b1;
        end
        check("midrst_no_resp", 32'(seen), 32'd0);
        fetch(2, 32'h80000000, 32'h00100093, 1'b0, 15, 0, 1'b0, 32'h0);
        fetch(0, 32'h80000014, 32'hCAFEF00D, 1'b0, 2, 0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
